// File: rtl/ex_mdu.sv
`default_nettype none
// ============================================================================
// Module      : ex_mdu
// Description : Iterative RISC-V M-extension multiply/divide unit. Radix-2
//               shift-add multiply and restoring divide, one bit per cycle,
//               with sign fix-up, W-form support and a single-cycle path
//               for divide-by-zero, signed overflow and illegal W encodings.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mdu #(
    parameter int XLEN     = 64,
    parameter bit WORD_OPS = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic            word_i,
    input  logic [XLEN-1:0] rs1_data_i,
    input  logic [XLEN-1:0] rs2_data_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            flush_i,
    output logic            ready_o,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o
);

    localparam int CW      = $clog2(XLEN + 1);
    localparam int PW      = 2 * XLEN;
    localparam int WSH     = XLEN - 32;
    localparam bit WORD_EN = (XLEN == 64) && WORD_OPS;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Sign-extend a 32-bit value to the datapath width
    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    logic [1:0]      state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d;     // product high half / partial remainder
    logic [XLEN-1:0] lo_q, lo_d;       // multiplier+product low / dividend+quotient
    logic [XLEN-1:0] b_q, b_d;         // multiplicand / divisor magnitude
    logic [2:0]      f3_q, f3_d;
    logic            word_q, word_d;
    logic            neg_q, neg_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] res_q, res_d;
    logic [4:0]      rdo_q, rdo_d;

    logic            w_word, w_sa_en, w_sb_en, w_a_neg, w_b_neg, w_neg;
    logic [XLEN-1:0] w_a_ext, w_b_ext, w_a_mag, w_b_mag, w_dividend;
    logic            w_div_zero, w_ovf, w_illegal, w_special;
    logic [XLEN-1:0] w_spec_res;

    // Operand preparation and special-case detection at accept
    always_comb begin
        w_word  = word_i & WORD_EN;
        w_a_ext = w_word ? XLEN'(rs1_data_i[31:0]) : rs1_data_i;
        w_b_ext = w_word ? XLEN'(rs2_data_i[31:0]) : rs2_data_i;
        w_sa_en = 1'b0;
        w_sb_en = 1'b0;
        case (funct3_i)
            3'b000, 3'b001, 3'b100, 3'b110: begin
                w_sa_en = 1'b1;
                w_sb_en = 1'b1;
            end
            3'b010:  w_sa_en = 1'b1;
            default: ;
        endcase
        w_a_neg = w_sa_en & (w_word ? rs1_data_i[31] : rs1_data_i[XLEN-1]);
        w_b_neg = w_sb_en & (w_word ? rs2_data_i[31] : rs2_data_i[XLEN-1]);
        w_a_mag = w_a_ext;
        if (w_a_neg)
            w_a_mag = w_word ? XLEN'(~rs1_data_i[31:0] + 32'd1) : (~rs1_data_i + XLEN'(1));
        w_b_mag = w_b_ext;
        if (w_b_neg)
            w_b_mag = w_word ? XLEN'(~rs2_data_i[31:0] + 32'd1) : (~rs2_data_i + XLEN'(1));
        // Remainder follows the dividend; everything else follows sign xor
        w_neg = (funct3_i == 3'b110) ? w_a_neg : (w_a_neg ^ w_b_neg);

        w_dividend = w_word ? sext32(rs1_data_i[31:0]) : rs1_data_i;
        w_div_zero = funct3_i[2] && (w_b_ext == '0);
        if (w_word)
            w_ovf = (rs1_data_i[31:0] == 32'h8000_0000) && (rs2_data_i[31:0] == 32'hFFFF_FFFF);
        else
            w_ovf = (rs1_data_i == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data_i == {XLEN{1'b1}});
        w_ovf     = w_ovf && funct3_i[2] && !funct3_i[0];
        w_illegal = w_word && !funct3_i[2] && (funct3_i[1:0] != 2'b00);
        w_special = w_div_zero | w_ovf | w_illegal;

        w_spec_res = '0;
        if (w_illegal)
            w_spec_res = '0;
        else if (w_div_zero)
            w_spec_res = funct3_i[1] ? w_dividend : {XLEN{1'b1}};
        else if (w_ovf)
            w_spec_res = funct3_i[1] ? '0 : w_dividend;
    end

    logic [XLEN-1:0] w_addend, w_it_acc, w_it_lo;
    logic [XLEN:0]   w_sum, w_shl, w_diff;
    logic            w_ge;

    // One multiply or divide step on the working registers
    always_comb begin
        w_addend = lo_q[0] ? b_q : '0;
        w_sum    = {1'b0, acc_q} + {1'b0, w_addend};
        w_shl    = {acc_q, lo_q[XLEN-1]};
        w_ge     = (w_shl >= {1'b0, b_q});
        w_diff   = w_shl - {1'b0, b_q};
        if (f3_q[2]) begin
            w_it_acc = w_ge ? w_diff[XLEN-1:0] : w_shl[XLEN-1:0];
            w_it_lo  = {lo_q[XLEN-2:0], w_ge};
        end else begin
            w_it_acc = w_sum[XLEN:1];
            w_it_lo  = {w_sum[0], lo_q[XLEN-1:1]};
        end
    end

    logic [PW-1:0]   w_prod;
    logic [XLEN-1:0] w_quo, w_rem, w_fix_res;

    // Sign correction and half/field select of the finished iteration
    always_comb begin
        w_prod = {acc_q, lo_q};
        // A 32-step W multiply leaves its product 32 bits up
        if (word_q)
            w_prod = w_prod >> 32;
        if (neg_q)
            w_prod = ~w_prod + PW'(1);
        w_quo = neg_q ? (~lo_q + XLEN'(1)) : lo_q;
        w_rem = neg_q ? (~acc_q + XLEN'(1)) : acc_q;
        if (f3_q[2])
            w_fix_res = f3_q[1] ? w_rem : w_quo;
        else
            w_fix_res = (f3_q[1:0] == 2'b00) ? w_prod[XLEN-1:0] : w_prod[PW-1:XLEN];
        if (word_q)
            w_fix_res = sext32(w_fix_res[31:0]);
    end

    // Control FSM and next-state of all datapath registers
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        lo_d    = lo_q;
        b_d     = b_q;
        f3_d    = f3_q;
        word_d  = word_q;
        neg_d   = neg_q;
        rd_d    = rd_q;
        res_d   = res_q;
        rdo_d   = rdo_q;
        case (state_q)
            S_IDLE: begin
                if (start_i && !flush_i) begin
                    f3_d   = funct3_i;
                    word_d = w_word;
                    rd_d   = rd_addr_i;
                    neg_d  = w_neg;
                    b_d    = w_b_mag;
                    if (w_special) begin
                        res_d   = w_spec_res;
                        rdo_d   = rd_addr_i;
                        cnt_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        acc_d   = '0;
                        // W divides must shift their 32-bit dividend out first
                        lo_d    = (funct3_i[2] && w_word) ? (w_a_mag << WSH) : w_a_mag;
                        cnt_d   = w_word ? CW'(32) : CW'(XLEN);
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                if (flush_i) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    acc_d = w_it_acc;
                    lo_d  = w_it_lo;
                    cnt_d = cnt_q - CW'(1);
                    if (cnt_q == CW'(1))
                        state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (flush_i) begin
                    state_d = S_IDLE;
                end else begin
                    res_d   = w_fix_res;
                    rdo_d   = rd_q;
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            f3_q    <= '0;
            word_q  <= 1'b0;
            neg_q   <= 1'b0;
            rd_q    <= '0;
            res_q   <= '0;
            rdo_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            f3_q    <= f3_d;
            word_q  <= word_d;
            neg_q   <= neg_d;
            rd_q    <= rd_d;
            res_q   <= res_d;
            rdo_q   <= rdo_d;
        end
    end

    assign ready_o   = (state_q == S_IDLE);
    assign stall_o   = (ready_o & start_i & ~flush_i) | (state_q == S_CALC) | (state_q == S_FIX);
    assign done_o    = (state_q == S_DONE) & ~flush_i;
    assign result_o  = res_q;
    assign rd_addr_o = rdo_q;

endmodule
`default_nettype wire

// File: tb/tb_ex_mdu.sv
`default_nettype none
// ============================================================================
// Module      : tb_ex_mdu
// Description : Directed self-checking bench for ex_mdu (XLEN=64).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ex_mdu;

    localparam logic [2:0] MUL = 3'b000, MULH = 3'b001, MULHSU = 3'b010, MULHU = 3'b011;
    localparam logic [2:0] DIV = 3'b100, DIVU = 3'b101, REM = 3'b110, REMU = 3'b111;
    localparam logic [63:0] ONES = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic [2:0]  funct3_i = '0;
    logic        word_i = 1'b0;
    logic [63:0] rs1_data_i = '0;
    logic [63:0] rs2_data_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        flush_i = 1'b0;
    logic        ready_o, stall_o, done_o;
    logic [63:0] result_o;
    logic [4:0]  rd_addr_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ex_mdu #(.XLEN(64), .WORD_OPS(1'b1)) dut (
        .clk        (clk),
        .rst        (rst),
        .start_i    (start_i),
        .funct3_i   (funct3_i),
        .word_i     (word_i),
        .rs1_data_i (rs1_data_i),
        .rs2_data_i (rs2_data_i),
        .rd_addr_i  (rd_addr_i),
        .flush_i    (flush_i),
        .ready_o    (ready_o),
        .stall_o    (stall_o),
        .done_o     (done_o),
        .result_o   (result_o),
        .rd_addr_o  (rd_addr_o)
    );

    // Present an operation request
    task automatic drive(input logic [2:0] f3, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [4:0] rd);
        funct3_i = f3; word_i = w; rs1_data_i = a; rs2_data_i = b; rd_addr_i = rd;
        start_i = 1'b1;
    endtask

    // Issue one op and wait (bounded) for done_o; lat = cycles after accept, -1 on timeout
    task automatic run_op(input logic [2:0] f3, input logic w, input logic [63:0] a,
                          input logic [63:0] b, input logic [4:0] rd,
                          output int lat, output logic [63:0] res, output logic [4:0] rdo);
        int n = 0;
        while (!ready_o && n < 200) begin @(posedge clk); #1; n++; end
        drive(f3, w, a, b, rd);
        @(posedge clk); #1;
        start_i = 1'b0;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            if (done_o) begin lat = c; break; end
            @(posedge clk); #1;
        end
        res = result_o;
        rdo = rd_addr_o;
    endtask

    task automatic test_reset();
        #1 rst = 1'b0;
        #2;
        n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", ready_o); end
        n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b want 0", done_o); end
        n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", stall_o); end
        n_cmp++; if (result_o !== 64'd0) begin n_bad++; $display("FAIL reset_result: got %h want 0", result_o); end
        n_cmp++; if (rd_addr_o !== 5'd0) begin n_bad++; $display("FAIL reset_rd: got %0d want 0", rd_addr_o); end
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_stall();
        drive(DIVU, 1'b0, 64'd5, 64'd0, 5'd1);
        #1;
        n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL stall_comb: got %b want 1", stall_o); end
        flush_i = 1'b1;
        #1;
        n_cmp++; if (stall_o !== 1'b0) begin n_bad++; $display("FAIL stall_flush: got %b want 0", stall_o); end
        @(posedge clk); #1;
        start_i = 1'b0; flush_i = 1'b0;
        n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL start_with_flush: ready got %b want 1", ready_o); end
    endtask

    task automatic test_mul();
        int lat; logic [63:0] r; logic [4:0] d;
        run_op(MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, lat, r, d);
        n_cmp++; if (lat != 66) begin n_bad++; $display("FAIL mul_latency: got %0d want 66", lat); end
        n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFEB) begin n_bad++; $display("FAIL mul_result: got %h want ffffffffffffffeb", r); end
        n_cmp++; if (d !== 5'd5) begin n_bad++; $display("FAIL mul_rd: got %0d want 5", d); end
        run_op(MULHU, 1'b0, ONES, ONES, 5'd6, lat, r, d);
        n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_bad++; $display("FAIL mulhu_result: got %h want fffffffffffffffe", r); end
        run_op(MULHSU, 1'b0, ONES, 64'd2, 5'd7, lat, r, d);
        n_cmp++; if (r !== ONES) begin n_bad++; $display("FAIL mulhsu_result: got %h want ffffffffffffffff", r); end
        run_op(MULH, 1'b0, 64'h8000_0000_0000_0000, 64'd4, 5'd8, lat, r, d);
        n_cmp++; if (r !== ONES - 64'd1) begin n_bad++; $display("FAIL mulh_result: got %h want fffffffffffffffe", r); end
    endtask

    task automatic test_div();
        int lat; logic [63:0] r; logic [4:0] d;
        run_op(DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd9, lat, r, d);
        n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFD) begin n_bad++; $display("FAIL div_result: got %h want fffffffffffffffd", r); end
        n_cmp++; if (lat != 66) begin n_bad++; $display("FAIL div_latency: got %0d want 66", lat); end
        run_op(REM, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd10, lat, r, d);
        n_cmp++; if (r !== ONES) begin n_bad++; $display("FAIL rem_result: got %h want ffffffffffffffff", r); end
        run_op(DIVU, 1'b0, 64'd100, 64'd7, 5'd11, lat, r, d);
        n_cmp++; if (r !== 64'd14) begin n_bad++; $display("FAIL divu_result: got %h want e", r); end
        run_op(REMU, 1'b0, 64'd100, 64'd7, 5'd12, lat, r, d);
        n_cmp++; if (r !== 64'd2) begin n_bad++; $display("FAIL remu_result: got %h want 2", r); end
        n_cmp++; if (d !== 5'd12) begin n_bad++; $display("FAIL remu_rd: got %0d want 12", d); end
    endtask

    task automatic test_special();
        int lat; logic [63:0] r; logic [4:0] d;
        run_op(DIVU, 1'b0, 64'd5, 64'd0, 5'd13, lat, r, d);
        n_cmp++; if (lat != 1 || r !== ONES) begin n_bad++; $display("FAIL divu_by_zero: got lat %0d res %h want lat 1 res ffffffffffffffff", lat, r); end
        run_op(REM, 1'b0, 64'd5, 64'd0, 5'd14, lat, r, d);
        n_cmp++; if (lat != 1 || r !== 64'd5) begin n_bad++; $display("FAIL rem_by_zero: got lat %0d res %h want lat 1 res 5", lat, r); end
        run_op(DIV, 1'b0, 64'h8000_0000_0000_0000, ONES, 5'd15, lat, r, d);
        n_cmp++; if (lat != 1 || r !== 64'h8000_0000_0000_0000) begin n_bad++; $display("FAIL div_overflow: got lat %0d res %h want lat 1 res 8000000000000000", lat, r); end
        run_op(REM, 1'b0, 64'h8000_0000_0000_0000, ONES, 5'd16, lat, r, d);
        n_cmp++; if (lat != 1 || r !== 64'd0) begin n_bad++; $display("FAIL rem_overflow: got lat %0d res %h want lat 1 res 0", lat, r); end
        n_cmp++; if (d !== 5'd16) begin n_bad++; $display("FAIL special_rd: got %0d want 16", d); end
        run_op(MULH, 1'b1, 64'd3, 64'd3, 5'd17, lat, r, d);
        n_cmp++; if (lat != 1 || r !== 64'd0) begin n_bad++; $display("FAIL illegal_w: got lat %0d res %h want lat 1 res 0", lat, r); end
    endtask

    task automatic test_word();
        int lat; logic [63:0] r; logic [4:0] d;
        run_op(DIV, 1'b1, 64'h1234_5678_8000_0000, ONES, 5'd18, lat, r, d);
        n_cmp++; if (lat != 1 || r !== 64'hFFFF_FFFF_8000_0000) begin n_bad++; $display("FAIL divw_overflow: got lat %0d res %h want lat 1 res ffffffff80000000", lat, r); end
        run_op(MUL, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'd19, lat, r, d);
        n_cmp++; if (lat != 34) begin n_bad++; $display("FAIL mulw_latency: got %0d want 34", lat); end
        n_cmp++; if (r !== 64'hFFFF_FFFF_FFFF_FFFE) begin n_bad++; $display("FAIL mulw_result: got %h want fffffffffffffffe", r); end
        run_op(REM, 1'b1, 64'hABCD_0000_FFFF_FFF9, 64'd2, 5'd20, lat, r, d);
        n_cmp++; if (lat != 34 || r !== ONES) begin n_bad++; $display("FAIL remw: got lat %0d res %h want lat 34 res ffffffffffffffff", lat, r); end
        run_op(DIVU, 1'b1, 64'hFFFF_FFFF_0000_0064, 64'h1_0000_0007, 5'd21, lat, r, d);
        n_cmp++; if (r !== 64'd14) begin n_bad++; $display("FAIL divuw: got %h want e", r); end
    endtask

    task automatic test_back_to_back();
        int lat; logic [63:0] r; logic [4:0] d;
        run_op(DIVU, 1'b0, 64'd100, 64'd7, 5'd3, lat, r, d);
        n_cmp++; if (ready_o !== 1'b0) begin n_bad++; $display("FAIL ready_in_done: got %b want 0", ready_o); end
        @(posedge clk); #1;
        n_cmp++; if (ready_o !== 1'b1 || done_o !== 1'b0) begin n_bad++; $display("FAIL ready_after_done: got ready %b done %b want 1 0", ready_o, done_o); end
        n_cmp++; if (result_o !== 64'd14 || rd_addr_o !== 5'd3) begin n_bad++; $display("FAIL result_hold: got %h/%0d want e/3", result_o, rd_addr_o); end
        run_op(REMU, 1'b0, 64'd100, 64'd7, 5'd4, lat, r, d);
        n_cmp++; if (lat != 66 || r !== 64'd2 || d !== 5'd4) begin n_bad++; $display("FAIL back_to_back: got lat %0d res %h rd %0d want 66 2 4", lat, r, d); end
        @(posedge clk); #1;
    endtask

    task automatic test_ignore_start();
        int lat; int extra;
        drive(DIV, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd7);
        @(posedge clk); #1;
        start_i = 1'b0;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            if (c == 3) drive(MUL, 1'b0, 64'd7, 64'd3, 5'd9);
            if (c == 4) start_i = 1'b0;
            if (done_o) begin lat = c; break; end
            @(posedge clk); #1;
        end
        n_cmp++; if (lat != 66 || result_o !== 64'hFFFF_FFFF_FFFF_FFFD || rd_addr_o !== 5'd7) begin
            n_bad++; $display("FAIL ignore_start: got lat %0d res %h rd %0d want 66 fffffffffffffffd 7", lat, result_o, rd_addr_o); end
        extra = 0;
        for (int c = 0; c < 80; c++) begin @(posedge clk); #1; if (done_o) extra++; end
        n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL ignore_start_extra_done: got %0d want 0", extra); end
    endtask

    task automatic test_flush();
        int extra;
        // previous result is REMU 100/7 -> 2 at rd 4? no: last is DIV -> fffd at rd 7
        drive(DIVU, 1'b0, 64'd100, 64'd7, 5'd11);
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 1; c < 10; c++) begin @(posedge clk); #1; end
        n_cmp++; if (stall_o !== 1'b1) begin n_bad++; $display("FAIL stall_in_calc: got %b want 1", stall_o); end
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL flush_ready: got %b want 1", ready_o); end
        n_cmp++; if (result_o !== 64'hFFFF_FFFF_FFFF_FFFD || rd_addr_o !== 5'd7) begin
            n_bad++; $display("FAIL flush_hold: got %h/%0d want fffffffffffffffd/7", result_o, rd_addr_o); end
        extra = 0;
        for (int c = 0; c < 80; c++) begin @(posedge clk); #1; if (done_o) extra++; end
        n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL flush_no_done: got %0d want 0", extra); end
        // Flush landing on the DONE cycle of a special case
        drive(DIVU, 1'b0, 64'd5, 64'd0, 5'd12);
        @(posedge clk); #1;
        start_i = 1'b0;
        flush_i = 1'b1;
        #1;
        n_cmp++; if (done_o !== 1'b0) begin n_bad++; $display("FAIL flush_in_done: got %b want 0", done_o); end
        @(posedge clk); #1;
        flush_i = 1'b0;
        n_cmp++; if (ready_o !== 1'b1) begin n_bad++; $display("FAIL flush_done_ready: got %b want 1", ready_o); end
    endtask

    task automatic test_reset_mid();
        int extra;
        drive(MUL, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd13);
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int c = 0; c < 20; c++) begin @(posedge clk); #1; end
        #1 rst = 1'b0;
        #1;
        n_cmp++; if (ready_o !== 1'b1 || stall_o !== 1'b0 || done_o !== 1'b0) begin
            n_bad++; $display("FAIL midreset_ctrl: got ready %b stall %b done %b want 1 0 0", ready_o, stall_o, done_o); end
        n_cmp++; if (result_o !== 64'd0 || rd_addr_o !== 5'd0) begin
            n_bad++; $display("FAIL midreset_outputs: got %h/%0d want 0/0", result_o, rd_addr_o); end
        #2 rst = 1'b1;
        extra = 0;
        for (int c = 0; c < 80; c++) begin @(posedge clk); #1; if (done_o) extra++; end
        n_cmp++; if (extra != 0) begin n_bad++; $display("FAIL midreset_no_done: got %0d want 0", extra); end
    endtask

    initial begin
        test_reset();
        test_stall();
        test_mul();
        test_div();
        test_special();
        test_word();
        test_back_to_back();
        test_ignore_start();
        test_flush();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
